// File: rtl/dds_pkg.sv
// Shared definitions for the DDS waveform generator: mode encodings, mid-scale helper
// and the elaboration-time quarter-sine table generator.
package dds_pkg;

  typedef enum logic [1:0] {
    DDS_SINE = 2'b00,
    DDS_TRI  = 2'b01,
    DDS_SQR  = 2'b10,
    DDS_DC   = 2'b11
  } dds_mode_e;

  localparam longint PI_Q28 = 64'sd843314857;

  function automatic int unsigned mid(input int unsigned out_w);
    return 32'd1 << (out_w - 32'd1);
  endfunction

  // round((2^mag_w-1)*sin(pi/2*(idx+0.5)/2^lut_aw)) via a Q28 Taylor series
  function automatic longint sine_entry(input longint idx, input longint lut_aw,
                                        input longint mag_w);
    longint x, x2, term, acc, full;
    x    = (PI_Q28 * (2 * idx + 1)) >>> (lut_aw + 2);
    x2   = (x * x) >>> 28;
    term = x;
    acc  = x;
    for (int unsigned k = 1; k <= 7; k++) begin
      term = ((term * x2) >>> 28) / (longint'(2 * k) * longint'(2 * k + 1));
      acc  = (k % 2 == 1) ? acc - term : acc + term;
    end
    full = (longint'(1) <<< mag_w) - 1;
    return (full * acc + (longint'(1) <<< 27)) >>> 28;
  endfunction

endpackage

// File: rtl/dds_quarter_lut.sv
// Registered quarter-wave sine ROM; contents are fixed at elaboration.
module dds_quarter_lut import dds_pkg::*; #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 7
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  output logic [DW-1:0] data_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] rom [DEPTH];
  logic [DW-1:0] data_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam longint Val = sine_entry(longint'(i), longint'(AW), longint'(DW));
    assign rom[i] = DW'(Val);
  end

  always_ff @(posedge clk_i) begin
    data_q <= rom[addr_i];
  end

  assign data_o = data_q;

endmodule

// File: rtl/dds_wave_gen.sv
// Phase-accumulator DDS: wrap-synchronised tuning word, phase offset, quarter-wave folding,
// four waveform modes and amplitude scaling, offset-binary output with per-period sync.
module dds_wave_gen import dds_pkg::*; #(
  parameter int unsigned PHASE_W = 16,
  parameter int unsigned LUT_AW  = 6,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned AMP_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PHASE_W-1:0] ftw,
  input  logic               ftw_load,
  input  logic [PHASE_W-1:0] phase_off,
  input  logic [1:0]         mode,
  input  logic [AMP_W-1:0]   amp,
  output logic [OUT_W-1:0]   wave_out,
  output logic               wave_valid,
  output logic               sync_pulse
);

  localparam int unsigned MAG_W = OUT_W - 1;
  localparam int unsigned PH_W  = LUT_AW + 2;
  localparam int unsigned PH_SH = PHASE_W - PH_W;
  localparam logic [OUT_W-1:0] MID    = OUT_W'(mid(OUT_W));
  localparam logic [OUT_W-1:0] MID_LO = OUT_W'(mid(OUT_W) - 32'd1);

  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PHASE_W-1:0] ftw_act_q, ftw_act_d;
  logic [PHASE_W-1:0] ftw_sh_q, ftw_sh_d;
  logic               pend_q, pend_d;
  logic [PHASE_W:0]   sum;
  logic               wrap;
  logic [PH_W-1:0]    ph_d;

  logic [PH_W-1:0]    ph_a_q;
  dds_mode_e          mode_a_q;
  logic [AMP_W-1:0]   amp_a_q;
  logic               vld_a_q, wrap_a_q;

  logic [1:0]         quad;
  logic [LUT_AW-1:0]  fold_a, addr;
  logic [MAG_W-1:0]   tri_mag;

  logic [MAG_W-1:0]   tri_b_q;
  logic               sign_b_q;
  dds_mode_e          mode_b_q;
  logic [AMP_W-1:0]   amp_b_q;
  logic               vld_b_q, wrap_b_q;
  logic [MAG_W-1:0]   rom_data;

  logic [MAG_W-1:0]   mag;
  logic [MAG_W-1:0]   scaled;
  logic [OUT_W-1:0]   wave_q, wave_d;
  logic               vld_q, sync_q;

  // S0: accumulator and tuning-word shadow
  assign sum  = {1'b0, acc_q} + {1'b0, ftw_act_q};
  assign wrap = en & sum[PHASE_W];
  assign ph_d = PH_W'((acc_q + phase_off) >> PH_SH);

  always_comb begin
    acc_d     = en ? sum[PHASE_W-1:0] : acc_q;
    ftw_sh_d  = ftw_sh_q;
    ftw_act_d = ftw_act_q;
    pend_d    = pend_q;
    // A zero tuning word never wraps, so a pending update must not wait for one
    if (ftw_load) begin
      ftw_sh_d = ftw;
      pend_d   = 1'b1;
    end else if (pend_q && (wrap || ftw_act_q == '0)) begin
      ftw_act_d = ftw_sh_q;
      pend_d    = 1'b0;
    end
  end

  // S1: quadrant fold into the quarter-wave address
  assign quad   = ph_a_q[PH_W-1 -: 2];
  assign fold_a = ph_a_q[LUT_AW-1:0];
  assign addr   = quad[0] ? ~fold_a : fold_a;

  if (LUT_AW >= MAG_W) begin : g_tri_trunc
    assign tri_mag = addr[LUT_AW-1 -: MAG_W];
  end else begin : g_tri_ext
    assign tri_mag = {{(MAG_W - LUT_AW){1'b0}}, addr};
  end

  dds_quarter_lut #(
    .AW (LUT_AW),
    .DW (MAG_W)
  ) u_lut (
    .clk_i  (clk),
    .addr_i (addr),
    .data_o (rom_data)
  );

  // S3: magnitude select, scaling and offset-binary mapping
  always_comb begin
    case (mode_b_q)
      DDS_SINE: mag = rom_data;
      DDS_TRI:  mag = tri_b_q;
      DDS_SQR:  mag = '1;
      default:  mag = '0;
    endcase
  end

  assign scaled = MAG_W'(({{AMP_W{1'b0}}, mag} * {{MAG_W{1'b0}}, amp_b_q}) >> AMP_W);

  always_comb begin
    wave_d = wave_q;
    if (vld_b_q) begin
      if (mode_b_q == DDS_DC) wave_d = MID;
      else if (sign_b_q)      wave_d = MID_LO - {1'b0, scaled};
      else                    wave_d = MID + {1'b0, scaled};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q     <= '0;
      ftw_act_q <= '0;
      ftw_sh_q  <= '0;
      pend_q    <= 1'b0;
      ph_a_q    <= '0;
      mode_a_q  <= DDS_SINE;
      amp_a_q   <= '0;
      vld_a_q   <= 1'b0;
      wrap_a_q  <= 1'b0;
      tri_b_q   <= '0;
      sign_b_q  <= 1'b0;
      mode_b_q  <= DDS_SINE;
      amp_b_q   <= '0;
      vld_b_q   <= 1'b0;
      wrap_b_q  <= 1'b0;
      wave_q    <= MID;
      vld_q     <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      ftw_act_q <= ftw_act_d;
      ftw_sh_q  <= ftw_sh_d;
      pend_q    <= pend_d;
      ph_a_q    <= ph_d;
      mode_a_q  <= dds_mode_e'(mode);
      amp_a_q   <= amp;
      vld_a_q   <= en;
      wrap_a_q  <= wrap;
      tri_b_q   <= tri_mag;
      sign_b_q  <= quad[1];
      mode_b_q  <= mode_a_q;
      amp_b_q   <= amp_a_q;
      vld_b_q   <= vld_a_q;
      wrap_b_q  <= wrap_a_q;
      wave_q    <= wave_d;
      vld_q     <= vld_b_q;
      sync_q    <= vld_b_q & wrap_b_q;
    end
  end

  assign wave_out   = wave_q;
  assign wave_valid = vld_q;
  assign sync_pulse = sync_q;

endmodule
